// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encodings and default PC parameters.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT   = 4;

endpackage

// File: rtl/pc_fetch_sequencer_jump_target_calc.sv
// Combinational redirect select (jr > j > branch) and target arithmetic, all modulo 2^32.
module jump_target_calc (
  input  logic        br_take,
  input  logic [15:0] br_off,
  input  logic        j_take,
  input  logic [25:0] j_index,
  input  logic        jr_take,
  input  logic [31:0] jr_addr,
  input  logic [31:0] redir_base,
  output logic        redir,
  output logic [31:0] target
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign br_target = redir_base + {{14{br_off[15]}}, br_off, 2'b00};
  assign j_target  = {redir_base[31:28], j_index, 2'b00};
  // Misaligned register targets are forced onto a word boundary; the top flags it.
  assign jr_target = {jr_addr[31:2], 2'b00};

  assign redir = jr_take | j_take | br_take;

  always_comb begin
    target = '0;
    if (jr_take)      target = jr_target;
    else if (j_take)  target = j_target;
    else if (br_take) target = br_target;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer with a one-entry decode buffer.
// Define PC_DELAY_SLOT_EN to keep the word at redir_base (delay slot) before redirecting.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int unsigned PC_STEP   = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_take,
  input  logic [15:0] br_off,
  input  logic        j_take,
  input  logic [25:0] j_index,
  input  logic        jr_take,
  input  logic [31:0] jr_addr,
  input  logic [31:0] redir_base,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        jr_misalign,
  output state_t      fsm_state
);

  // Handshake: once imem_req rises it stays high with imem_addr stable until the cycle
  // imem_ack is high; that cycle completes the transfer and imem_rdata is sampled.

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] tgt, tgt_n;
  logic        busy, busy_n;
  logic        if_valid_n;
  logic [31:0] if_instr_n, if_pc_n;
  logic        misalign_n;
  logic        redir;
  logic [31:0] target;
  logic        accept;
  logic [31:0] pc_seq;

`ifdef PC_DELAY_SLOT_EN
  logic        pend, pend_n;
  logic [31:0] pend_base, pend_base_n;
  logic        eff_pend;
  logic [31:0] eff_tgt, eff_base;

  assign eff_pend = pend | redir;
  assign eff_tgt  = redir ? target : tgt;
  assign eff_base = redir ? redir_base : pend_base;
`endif

  jump_target_calc u_jump_target_calc (
    .br_take    (br_take),
    .br_off     (br_off),
    .j_take     (j_take),
    .j_index    (j_index),
    .jr_take    (jr_take),
    .jr_addr    (jr_addr),
    .redir_base (redir_base),
    .redir      (redir),
    .target     (target)
  );

  assign pc_seq    = pc + 32'(PC_STEP);
  assign fsm_state = state;

  // A new request is withheld while decode is stalled on a full buffer, but a request
  // already on the bus (busy) is never withdrawn.
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      S_FETCH: imem_req = busy || !(if_valid && stall);
      S_FLUSH: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = imem_req ? pc : '0;
  assign accept    = (state == S_FETCH) && imem_req && imem_ack && (!if_valid || !stall);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tgt_n      = tgt;
    busy_n     = imem_req && !imem_ack;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc_n    = if_pc;
    misalign_n = jr_misalign | (jr_take && (jr_addr[1:0] != 2'b00));
`ifdef PC_DELAY_SLOT_EN
    pend_n      = pend;
    pend_base_n = pend_base;
`endif
    unique case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH, S_HOLD: begin
        if (accept) begin
          if_instr_n = imem_rdata;
          if_pc_n    = pc;
          if_valid_n = 1'b1;
          pc_n       = pc_seq;
        end else if (!stall) begin
          if_valid_n = 1'b0;
        end
        // An ack that lands while the buffer is full and stalled is dropped; pc is not
        // advanced, so the same word is fetched again after the hold.
        if (state == S_HOLD)
          state_n = stall ? S_HOLD : S_FETCH;
        else if (if_valid && stall && (!imem_req || imem_ack))
          state_n = S_HOLD;
`ifdef PC_DELAY_SLOT_EN
        if (eff_pend && (pc != eff_base)) begin
          // Delay slot already fetched: anything beyond it is discarded.
          pend_n     = 1'b0;
          if_valid_n = if_valid && stall;
          if_instr_n = if_instr;
          if_pc_n    = if_pc;
          if (imem_req && !imem_ack) begin
            tgt_n   = eff_tgt;
            state_n = S_FLUSH;
          end else begin
            pc_n    = eff_tgt;
            state_n = S_FETCH;
          end
        end else if (eff_pend) begin
          pend_n      = 1'b1;
          tgt_n       = eff_tgt;
          pend_base_n = eff_base;
          if (accept) begin
            pc_n   = eff_tgt;
            pend_n = 1'b0;
          end
        end
`else
        if (redir) begin
          if_valid_n = 1'b0;
          if_instr_n = if_instr;
          if_pc_n    = if_pc;
          if (imem_req && !imem_ack) begin
            tgt_n   = target;
            state_n = S_FLUSH;
          end else begin
            pc_n    = target;
            state_n = S_FETCH;
          end
        end
`endif
      end
      S_FLUSH: begin
`ifdef PC_DELAY_SLOT_EN
        pend_n = 1'b0;
`endif
        if (imem_ack) begin
          pc_n    = redir ? target : tgt;
          state_n = S_FETCH;
        end else if (redir) begin
          tgt_n = target;
        end
      end
      default: state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      pc          <= RESET_VEC;
      tgt         <= '0;
      busy        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      jr_misalign <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pend        <= 1'b0;
      pend_base   <= '0;
`endif
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      tgt         <= tgt_n;
      busy        <= busy_n;
      if_valid    <= if_valid_n;
      if_instr    <= if_instr_n;
      if_pc       <= if_pc_n;
      jr_misalign <= misalign_n;
`ifdef PC_DELAY_SLOT_EN
      pend        <= pend_n;
      pend_base   <= pend_base_n;
`endif
    end
  end

endmodule
